// File: rtl/bitop_pipe.sv
// bitop_pipe: pipelined half-add / serial multi-beat adder with packet FSM and valid/ready flow control
module bitop_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_carry,
    output logic             out_last,
    output logic [7:0]       out_beats
);
    typedef enum logic {IDLE, PKT} state_t;

    state_t           state;
    logic             carry_reg;
    logic [7:0]       beat_cnt;
    logic [STAGES-1:0] s_valid;
    logic [WIDTH-1:0] s_sum   [STAGES];
    logic [WIDTH-1:0] s_carry [STAGES];
    logic             s_last  [STAGES];
    logic [7:0]       s_beats [STAGES];
    logic             advance;
    logic             accept;
    logic             mode;
    logic             cin;
    logic             c;
    logic [WIDTH:0]   add;
    logic [WIDTH-1:0] nxt_sum;
    logic [WIDTH-1:0] nxt_carry;
    logic             nxt_last;
    logic [7:0]       nxt_beats;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && advance;
    assign out_valid = s_valid[STAGES-1];
    assign out_sum   = s_sum[STAGES-1];
    assign out_carry = s_carry[STAGES-1];
    assign out_last  = s_last[STAGES-1];
    assign out_beats = s_beats[STAGES-1];

    // Result of the beat on the inputs; inside a packet the latched add mode overrides in_mode
    always_comb begin
        mode      = (state == PKT) || in_mode;
        cin       = (state == PKT) && carry_reg;
        add       = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, cin};
        c         = add[WIDTH];
        nxt_sum   = mode ? add[WIDTH-1:0] : in_a ^ in_b;
        nxt_carry = mode ? WIDTH'(c) : in_a & in_b;
        nxt_last  = mode ? in_last : 1'b1;
        nxt_beats = (state == PKT) ? beat_cnt : 8'd0;
    end

    // Packet FSM with carry chain and saturating beat counter, advanced only by accepted add beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            carry_reg <= 1'b0;
            beat_cnt  <= 8'd0;
        end else if (accept && mode) begin
            if (in_last) begin
                state     <= IDLE;
                carry_reg <= 1'b0;
                beat_cnt  <= 8'd0;
            end else begin
                state     <= PKT;
                carry_reg <= c;
                beat_cnt  <= (state == IDLE) ? 8'd1 : (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
            end
        end
    end

    // Result pipeline: shifts on advance, stage 0 takes the new result or a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                s_sum[i]   <= '0;
                s_carry[i] <= '0;
                s_last[i]  <= 1'b0;
                s_beats[i] <= 8'd0;
            end
        end else if (advance) begin
            s_valid[0] <= accept;
            s_sum[0]   <= nxt_sum;
            s_carry[0] <= nxt_carry;
            s_last[0]  <= nxt_last;
            s_beats[0] <= nxt_beats;
            for (int i = 1; i < STAGES; i++) begin
                s_valid[i] <= s_valid[i-1];
                s_sum[i]   <= s_sum[i-1];
                s_carry[i] <= s_carry[i-1];
                s_last[i]  <= s_last[i-1];
                s_beats[i] <= s_beats[i-1];
            end
        end
    end
endmodule
